// File: rtl/eeg_pea_pkg.sv
// Shared types and defaults for the PE array output collector.
// Holds array geometry defaults, the collector FSM states and the ORAM write-register layout.
package eeg_pea_pkg;

    localparam int PE_ROW_DEF      = 4;
    localparam int PE_COL_DEF      = 4;
    localparam int PE_OUT_DW_DEF   = 8;
    localparam int ORAM_ADD_AW_DEF = 8;

    // Index width for n streams; a single stream still needs one bit.
    function automatic int idx_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PE_NUM_DEF    = PE_ROW_DEF * PE_COL_DEF;
    localparam int PE_IDX_AW_DEF = idx_aw(PE_NUM_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } col_state_e;

    // One pending ORAM write: source PE, its local address, its data.
    typedef struct packed {
        logic [PE_IDX_AW_DEF-1:0]   idx;
        logic [ORAM_ADD_AW_DEF-1:0] add;
        logic [PE_OUT_DW_DEF-1:0]   dat;
    } wr_reg_t;

endpackage

// File: rtl/eeg_rr_arb.sv
// Round-robin arbiter over N requesters with a registered priority pointer.
// Ports: clk, rst (sync, active-high), clr (pointer to N-1), en, req[N], gnt (one-hot), gnt_idx, gnt_vld.
module eeg_rr_arb
    import eeg_pea_pkg::*;
#(
    parameter int N  = PE_NUM_DEF,
    parameter int AW = idx_aw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [AW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [AW-1:0] ptr;
    logic [AW:0]   sum;
    logic [AW-1:0] cand;

    // Walk ptr+1 .. ptr+N modulo N; the first requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr} + (AW+1)'(i);
            if (sum >= (AW+1)'(N)) begin
                sum = sum - (AW+1)'(N);
            end
            cand = sum[AW-1:0];
            if (en && !gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Pointer parks on N-1 so a fresh pass searches from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= AW'(N - 1);
        end else if (clr) begin
            ptr <= AW'(N - 1);
        end else if (gnt_vld) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/eeg_pea_out_col.sv
// PE array output collector: round-robin merge of per-PE output streams onto one ORAM write port.
// Ports: clk, rst (sync, active-high); START/IS_IDLE/DONE/ERR control; IN_VLD/IN_LST/IN_RDY/IN_DAT/IN_ADD
// per-PE streams; ORAM_WEN/ORAM_RDY/ORAM_ADD/ORAM_DAT write port. Optional checker: EEG_PEA_OUT_COL_CHK_EN.
module eeg_pea_out_col
    import eeg_pea_pkg::*;
#(
    parameter  int PE_ROW      = PE_ROW_DEF,
    parameter  int PE_COL      = PE_COL_DEF,
    parameter  int PE_OUT_DW   = PE_OUT_DW_DEF,
    parameter  int ORAM_ADD_AW = ORAM_ADD_AW_DEF,
    localparam int PE_NUM      = PE_ROW * PE_COL,
    localparam int PE_IDX_AW   = idx_aw(PE_NUM)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         START,
    output logic                                         IS_IDLE,
    output logic                                         DONE,
    output logic                                         ERR,
    input  logic [PE_ROW-1:0][PE_COL-1:0]                IN_VLD,
    input  logic [PE_ROW-1:0][PE_COL-1:0]                IN_LST,
    output logic [PE_ROW-1:0][PE_COL-1:0]                IN_RDY,
    input  logic [PE_ROW-1:0][PE_COL-1:0][PE_OUT_DW-1:0] IN_DAT,
    input  logic [PE_ROW-1:0][PE_COL-1:0][ORAM_ADD_AW-1:0] IN_ADD,
    output logic                                         ORAM_WEN,
    input  logic                                         ORAM_RDY,
    output logic [PE_IDX_AW+ORAM_ADD_AW-1:0]             ORAM_ADD,
    output logic [PE_OUT_DW-1:0]                         ORAM_DAT
);

    // Row-major flattening gives bit k = row*PE_COL + col.
    logic [PE_NUM-1:0]                  vld_f;
    logic [PE_NUM-1:0]                  lst_f;
    logic [PE_NUM-1:0][PE_OUT_DW-1:0]   dat_f;
    logic [PE_NUM-1:0][ORAM_ADD_AW-1:0] add_f;

    assign vld_f = IN_VLD;
    assign lst_f = IN_LST;
    assign dat_f = IN_DAT;
    assign add_f = IN_ADD;

    col_state_e state;
    col_state_e state_nxt;

    logic [PE_NUM-1:0]    lst_flag;
    logic [PE_NUM-1:0]    lst_nxt;
    logic [PE_NUM-1:0]    elig;
    logic [PE_NUM-1:0]    gnt;
    logic [PE_IDX_AW-1:0] gnt_idx;
    logic                 gnt_vld;

    wr_reg_t wr_q;
    wr_reg_t wr_d;
    logic    wr_vld;

    logic can_load;
    logic start_ok;
    logic arb_en;
    logic all_lst;

    // Register can take a new word when empty or being drained this cycle.
    assign can_load = !wr_vld || ORAM_RDY;
    assign start_ok = START && (state == ST_IDLE);
    assign arb_en   = (state == ST_RUN) && can_load;
    assign elig     = vld_f & ~lst_flag;

    // Include the last flag of the word granted this cycle.
    assign lst_nxt  = lst_flag | (gnt & lst_f);
    assign all_lst  = &lst_nxt;

    eeg_rr_arb #(
        .N  (PE_NUM),
        .AW (PE_IDX_AW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (arb_en),
        .req     (elig),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Ready depends on valid: the grant is built from IN_VLD this cycle.
    assign IN_RDY = gnt;

    always_comb begin
        wr_d     = '0;
        wr_d.idx = gnt_idx;
        wr_d.add = add_f[gnt_idx];
        wr_d.dat = dat_f[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (all_lst) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (can_load) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Last flags persist until the next accepted START.
    always_ff @(posedge clk) begin
        if (rst) begin
            lst_flag <= '0;
        end else if (start_ok) begin
            lst_flag <= '0;
        end else if (gnt_vld) begin
            lst_flag <= lst_nxt;
        end
    end

    // Write stage: load on grant, otherwise clear once ORAM takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld <= 1'b0;
            wr_q   <= '0;
        end else if (gnt_vld) begin
            wr_vld <= 1'b1;
            wr_q   <= wr_d;
        end else if (wr_vld && ORAM_RDY) begin
            wr_vld <= 1'b0;
        end
    end

    assign ORAM_WEN = wr_vld;
    assign ORAM_ADD = {wr_q.idx, wr_q.add};
    assign ORAM_DAT = wr_q.dat;
    assign IS_IDLE  = (state == ST_IDLE);
    assign DONE     = (state == ST_DONE);

`ifdef EEG_PEA_OUT_COL_CHK_EN
    logic err_q;
    logic in_pass;
    logic bad_vld;

    assign in_pass = (state == ST_RUN) || (state == ST_DRAIN);
    assign bad_vld = in_pass && |(vld_f & lst_flag);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (START && (state != ST_IDLE)) begin
            err_q <= 1'b1;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (bad_vld) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_eeg_pea_out_col.sv
// Self-checking bench for eeg_pea_out_col: random PE streams, scoreboard of expected ORAM writes.
// Expected order comes from a round-robin model over per-PE word queues.
module tb_eeg_pea_out_col;

    localparam int NPE = 16;

`ifdef EEG_PEA_OUT_COL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic START;
    logic IS_IDLE;
    logic DONE;
    logic ERR;
    logic [3:0][3:0] IN_VLD;
    logic [3:0][3:0] IN_LST;
    logic [3:0][3:0] IN_RDY;
    logic [3:0][3:0][7:0] IN_DAT;
    logic [3:0][3:0][7:0] IN_ADD;
    logic ORAM_WEN;
    logic ORAM_RDY;
    logic [11:0] ORAM_ADD;
    logic [7:0] ORAM_DAT;

    logic [NPE-1:0] vld_f;
    logic [NPE-1:0] lst_f;
    logic [NPE-1:0][7:0] dat_f;
    logic [NPE-1:0][7:0] add_f;

    assign IN_VLD = vld_f;
    assign IN_LST = lst_f;
    assign IN_DAT = dat_f;
    assign IN_ADD = add_f;

    eeg_pea_out_col dut (
        .clk      (clk),
        .rst      (rst),
        .START    (START),
        .IS_IDLE  (IS_IDLE),
        .DONE     (DONE),
        .ERR      (ERR),
        .IN_VLD   (IN_VLD),
        .IN_LST   (IN_LST),
        .IN_RDY   (IN_RDY),
        .IN_DAT   (IN_DAT),
        .IN_ADD   (IN_ADD),
        .ORAM_WEN (ORAM_WEN),
        .ORAM_RDY (ORAM_RDY),
        .ORAM_ADD (ORAM_ADD),
        .ORAM_DAT (ORAM_DAT)
    );

    typedef struct packed {
        logic [7:0] add;
        logic [7:0] dat;
        logic       lst;
    } wd_t;

    typedef struct packed {
        logic [11:0] add;
        logic [7:0]  dat;
    } ex_t;

    wd_t pq[NPE][$];
    ex_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_acc = 0;
    int first_acc = 0;
    int last_acc = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    bit hold3 = 1'b0;
    bit rdy_rand = 1'b0;
    logic [NPE-1:0] gnt_s = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Producers: each PE presents its queue head; pops after a grant.
    initial begin
        vld_f = '0;
        lst_f = '0;
        dat_f = '0;
        add_f = '0;
        ORAM_RDY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NPE; k++) begin
                if (gnt_s[k] && pq[k].size() > 0) pq[k].delete(0);
                if (pq[k].size() > 0) begin
                    vld_f[k] = 1'b1;
                    lst_f[k] = pq[k][0].lst;
                    add_f[k] = pq[k][0].add;
                    dat_f[k] = pq[k][0].dat;
                end else if (hold3 && k == 3) begin
                    vld_f[k] = 1'b1;
                    lst_f[k] = 1'b1;
                    add_f[k] = 8'hEE;
                    dat_f[k] = 8'h55;
                end else begin
                    vld_f[k] = 1'b0;
                    lst_f[k] = 1'b0;
                end
            end
            if (stall_cnt > 0) begin
                ORAM_RDY = 1'b0;
                stall_cnt--;
            end else if (rdy_rand) begin
                ORAM_RDY = ($urandom_range(0, 3) != 0);
            end else begin
                ORAM_RDY = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted ORAM write.
    initial begin
        bit prev_stall;
        logic [11:0] st_add;
        logic [7:0] st_dat;
        ex_t e;
        prev_stall = 1'b0;
        st_add = '0;
        st_dat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                gnt_s = '0;
            end else begin
                gnt_s = IN_RDY;
                chk("rdy_onehot0", 32'($onehot0(IN_RDY)), 1);
                if (prev_stall) begin
                    chk("stall_wen", ORAM_WEN, 1);
                    chk("stall_add", ORAM_ADD, st_add);
                    chk("stall_dat", ORAM_DAT, st_dat);
                end
                if (ORAM_WEN && !ORAM_RDY) begin
                    chk("stall_in_rdy", IN_RDY, 0);
                    prev_stall = 1'b1;
                    st_add = ORAM_ADD;
                    st_dat = ORAM_DAT;
                end else begin
                    prev_stall = 1'b0;
                end
                if (ORAM_WEN && ORAM_RDY) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL extra_write: got add %0h dat %0h, expected no write", ORAM_ADD, ORAM_DAT);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_add", ORAM_ADD, e.add);
                        chk("wr_dat", ORAM_DAT, e.dat);
                    end
                    if (n_acc == 0) first_acc = cyc;
                    last_acc = cyc;
                    n_acc++;
                end
                if (DONE) begin
                    chk("done_lat", cyc, last_acc + 1);
                    chk("done_sb_empty", sb.size(), 0);
                    done_cnt++;
                end
            end
        end
    end

    // Reference: with producers always valid while they hold words,
    // grants visit PEs with remaining words in cyclic order from 0.
    task automatic build_expected();
        int cnt[NPE];
        int pos[NPE];
        int ptr;
        int total;
        int k;
        total = 0;
        for (int i = 0; i < NPE; i++) begin
            cnt[i] = pq[i].size();
            pos[i] = 0;
            total += cnt[i];
        end
        ptr = NPE - 1;
        repeat (total) begin
            for (int i = 1; i <= NPE; i++) begin
                k = (ptr + i) % NPE;
                if (cnt[k] > 0) break;
            end
            sb.push_back(ex_t'{add: {4'(k), pq[k][pos[k]].add}, dat: pq[k][pos[k]].dat});
            pos[k]++;
            cnt[k]--;
            ptr = k;
        end
    endtask

    task automatic fill_random(input int minw, input int maxw);
        int nw;
        for (int k = 0; k < NPE; k++) begin
            nw = $urandom_range(minw, maxw);
            for (int i = 0; i < nw; i++)
                pq[k].push_back(wd_t'{add: 8'($urandom), dat: 8'($urandom), lst: (i == nw - 1)});
        end
    endtask

    task automatic fill_directed();
        for (int k = 0; k < NPE; k++) begin
            if (k == 5) begin
                for (int i = 0; i < 3; i++)
                    pq[k].push_back(wd_t'{add: 8'(8'h10 + i), dat: 8'(8'hA0 + i), lst: (i == 2)});
            end else begin
                pq[k].push_back(wd_t'{add: 8'($urandom), dat: 8'($urandom), lst: 1'b1});
            end
        end
    endtask

    task automatic flush_all();
        sb.delete();
        for (int k = 0; k < NPE; k++) pq[k].delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 START = 1'b1;
        @(posedge clk);
        #1 START = 1'b0;
    endtask

    task automatic run_pass(input bit hold, input bit smid, input bit stl, input bit rr, input bit gap);
        int exp_n;
        int d0;
        int t;
        build_expected();
        exp_n = sb.size();
        n_acc = 0;
        d0 = done_cnt;
        hold3 = hold;
        rdy_rand = rr;
        pulse_start();
        @(negedge clk);
        chk("run_not_idle", IS_IDLE, 0);
        chk("err_clr", ERR, 0);
        if (smid || stl) begin
            t = 0;
            while (n_acc < 5 && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("mid_reached", 32'(n_acc >= 5), 1);
            if (stl) stall_cnt = 4;
            if (smid) begin
                pulse_start();
                @(negedge clk);
                chk("smid_not_idle", IS_IDLE, 0);
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt != d0), 1);
        chk("n_writes", n_acc, exp_n);
        chk("err_end", ERR, 32'(CHK && (hold || smid)));
        if (gap) chk("no_gaps", last_acc - first_acc, exp_n - 1);
        hold3 = 1'b0;
        rdy_rand = 1'b0;
        @(negedge clk);
        chk("idle_after", IS_IDLE, 1);
        chk("done_one_cycle", DONE, 0);
        flush_all();
    endtask

    task automatic rst_test();
        int t;
        fill_random(2, 4);
        build_expected();
        n_acc = 0;
        rdy_rand = 1'b0;
        pulse_start();
        t = 0;
        while (n_acc < 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached", 32'(n_acc >= 4), 1);
        stall_cnt = 1000;
        @(negedge clk);
        chk("rst_pending_wen", ORAM_WEN, 1);
        chk("rst_pending_busy", IS_IDLE, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        flush_all();
        stall_cnt = 0;
        @(negedge clk);
        chk("rst_wen", ORAM_WEN, 0);
        chk("rst_idle", IS_IDLE, 1);
        chk("rst_in_rdy", IN_RDY, 0);
        chk("rst_add", ORAM_ADD, 0);
        chk("rst_err", ERR, 0);
    endtask

    initial begin
        rst = 1'b1;
        START = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_is_idle", IS_IDLE, 1);
        chk("reset_done", DONE, 0);
        chk("reset_err", ERR, 0);
        chk("reset_in_rdy", IN_RDY, 0);
        chk("reset_wen", ORAM_WEN, 0);
        chk("reset_add", ORAM_ADD, 0);
        chk("reset_dat", ORAM_DAT, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        fill_directed();
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        fill_random(3, 3);
        run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        fill_random(2, 4);
        run_pass(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        fill_random(1, 4);
        run_pass(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        fill_random(1, 4);
        run_pass(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        fill_random(2, 4);
        run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_test();
        fill_random(1, 3);
        run_pass(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int p = 0; p < 4; p++) begin
            fill_random(1, 5);
            run_pass(1'b0, 1'b0, 1'(p % 2), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
